// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-port controller for the GPR register file. Arbitrates the EXU and
//   LSU writeback requests onto the single RF write port and keeps a
//   per-register busy scoreboard for decode RAW/WAW hazard detection.
//
// Optional feature macro: RF_WB_RR_EN
//   defined   : round-robin arbitration on conflict (reset favours EXU)
//   undefined : fixed priority, LSU wins over EXU on conflict
//
// Ports
//   clk, rstn             clock (rising edge), synchronous active-low reset
//   exu_valid/ready/rd/data   EXU writeback request and combinational grant
//   lsu_valid/ready/rd/data   LSU writeback request and combinational grant
//   iss_valid/ready/rd        decode issue; accepted issue marks iss_rd busy
//   rs1, rs2 / rs1_busy, rs2_busy   combinational scoreboard lookups (x0 never busy)
//   rf_wen, rf_waddr, rf_wdata      registered RF write port
//   busy_vec                         scoreboard bits, bit 0 tied to 0
module rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         exu_valid,
    output logic                         exu_ready,
    input  logic [ADDR_WIDTH-1:0]        exu_rd,
    input  logic [DATA_WIDTH-1:0]        exu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    input  logic [ADDR_WIDTH-1:0]        rs1,
    input  logic [ADDR_WIDTH-1:0]        rs2,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec
);

    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_next;
    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

`ifdef RF_WB_RR_EN
    typedef enum logic {
        LAST_EXU,
        LAST_LSU
    } last_t;

    last_t last_grant;

    // On conflict the requester that did not win last time is granted.
    always_comb begin
        exu_ready = exu_valid && (!lsu_valid || (last_grant == LAST_LSU));
        lsu_ready = lsu_valid && (!exu_valid || (last_grant == LAST_EXU));
    end

    // Pointer only moves on a conflicting grant; reset state favours EXU.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant <= LAST_LSU;
        end else if (exu_valid && lsu_valid) begin
            last_grant <= exu_ready ? LAST_EXU : LAST_LSU;
        end
    end
`else
    always_comb begin
        lsu_ready = lsu_valid;
        exu_ready = exu_valid && !lsu_valid;
    end
`endif

    always_comb begin
        wb_fire = (exu_valid && exu_ready) || (lsu_valid && lsu_ready);
        wb_rd   = lsu_ready ? lsu_rd   : exu_rd;
        wb_data = lsu_ready ? lsu_data : exu_data;
    end

    // Writes to x0 are accepted but never reach the RF; address/data hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= wb_fire && (wb_rd != '0);
            if (wb_fire && (wb_rd != '0)) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end
        end
    end

    always_comb begin
        iss_ready = !busy[iss_rd] || (iss_rd == '0);
        rs1_busy  = busy[rs1] && (rs1 != '0);
        rs2_busy  = busy[rs2] && (rs2 != '0);
    end

    // Clear applied before set so a new producer issued at the retiring
    // edge keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          exu_valid, exu_ready;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          iss_valid, iss_ready;
    logic [AW-1:0] iss_rd, rs1, rs2;
    logic          rs1_busy, rs2_busy;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NREG-1:0] busy_vec;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: scoreboard as a plain bit set, the RF write port as
    // three values, and for round-robin the identity of the last conflict winner.
    bit [NREG-1:0] m_busy;
    bit            m_wen;
    bit [AW-1:0]   m_waddr;
    bit [DW-1:0]   m_wdata;
    bit            m_acc_exu, m_acc_lsu;
`ifdef RF_WB_RR_EN
    int            m_last;   // 1 = EXU won last conflict, 2 = LSU
`endif

    // 0 = nobody, 1 = EXU, 2 = LSU
    function automatic int winner();
        if (exu_valid && lsu_valid) begin
`ifdef RF_WB_RR_EN
            return (m_last == 1) ? 2 : 1;
`else
            return 2;
`endif
        end
        if (exu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int      w;
        bit      iss_ok;
        bit [AW-1:0] rd;
        if (!rstn) begin
            m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            m_acc_exu = 1'b0; m_acc_lsu = 1'b0;
`ifdef RF_WB_RR_EN
            m_last = 2;
`endif
        end else begin
            w      = winner();
            iss_ok = iss_valid && ((iss_rd == 0) || !m_busy[iss_rd]);
            if (m_wen) m_busy[m_waddr] = 1'b0;
            if (iss_ok && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            rd = (w == 2) ? lsu_rd : exu_rd;
            if (w != 0 && rd != 0) begin
                m_wen   = 1'b1;
                m_waddr = rd;
                m_wdata = (w == 2) ? lsu_data : exu_data;
            end else begin
                m_wen = 1'b0;
            end
            m_acc_exu = (w == 1);
            m_acc_lsu = (w == 2);
`ifdef RF_WB_RR_EN
            if (exu_valid && lsu_valid) m_last = w;
`endif
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int w;
        if (chk_en) begin
            w = winner();
            chk("exu_ready", 64'(exu_ready), 64'(w == 1));
            chk("lsu_ready", 64'(lsu_ready), 64'(w == 2));
            chk("iss_ready", 64'(iss_ready), 64'((iss_rd == 0) || !m_busy[iss_rd]));
            chk("rs1_busy",  64'(rs1_busy),  64'((rs1 != 0) && m_busy[rs1]));
            chk("rs2_busy",  64'(rs2_busy),  64'((rs2 != 0) && m_busy[rs2]));
            chk("rf_wen",    64'(rf_wen),    64'(m_wen));
            chk("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
            chk("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
            chk("busy_vec",  64'(busy_vec),  64'(m_busy));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_rd();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rstn = 1'b0;
        exu_valid = 0; exu_rd = '0; exu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
        step(); step();
        rstn = 1'b1; chk_en = 1'b1;
        #2;
        chk("rst_wen",   64'(rf_wen),   64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_busy",  64'(busy_vec), 64'd0);

        // Reset mid-operation
        step();
        iss_valid = 1; iss_rd = 5'd3;
        exu_valid = 1; exu_rd = 5'd1; exu_data = 32'hAB;
        step();
        iss_valid = 0; exu_valid = 0;
        #2;
        chk("t1_busy",   64'(busy_vec), 64'h8);
        chk("t1_wen",    64'(rf_wen),   64'd1);
        chk("t1_waddr",  64'(rf_waddr), 64'd1);
        chk("t1_wdata",  64'(rf_wdata), 64'hAB);
        chk("t1_mbusy",  64'(m_busy),   64'h8);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #2;
        chk("t1_r_busy",  64'(busy_vec), 64'd0);
        chk("t1_r_wen",   64'(rf_wen),   64'd0);
        chk("t1_r_waddr", 64'(rf_waddr), 64'd0);
        chk("t1_r_wdata", 64'(rf_wdata), 64'd0);

        // Issue then EXU writeback, no forwarding
        step();
        iss_valid = 1; iss_rd = 5'd5; rs1 = 5'd5;
        step();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 5'd5; exu_data = 32'h1234;
        #2;
        chk("t2_busy",  64'(busy_vec),  64'h20);
        chk("t2_rs1a",  64'(rs1_busy),  64'd1);
        chk("t2_exurdy",64'(exu_ready), 64'd1);
        step();
        exu_valid = 0;
        #2;
        chk("t2_wen",   64'(rf_wen),   64'd1);
        chk("t2_waddr", 64'(rf_waddr), 64'd5);
        chk("t2_wdata", 64'(rf_wdata), 64'h1234);
        chk("t2_rs1b",  64'(rs1_busy), 64'd1);
        chk("t2_mwen",  64'(m_wen),    64'd1);
        step();
        #2;
        chk("t2_rs1c",  64'(rs1_busy), 64'd0);
        chk("t2_wen0",  64'(rf_wen),   64'd0);
        chk("t2_hold",  64'(rf_waddr), 64'd5);
        chk("t2_busy0", 64'(busy_vec), 64'd0);

        // WAW stall on x7, release, and set-wins on a simultaneous clear
        step();
        iss_valid = 1; iss_rd = 5'd7;
        step();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h77;
        step();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 5'd7;
        #2;
        chk("t5_wen",    64'(rf_wen),    64'd1);
        chk("t5_waddr",  64'(rf_waddr),  64'd7);
        chk("t5_stall",  64'(iss_ready), 64'd0);
        step();
        #2;
        chk("t5_free",   64'(iss_ready), 64'd1);
        chk("t5_busy0",  64'(busy_vec),  64'd0);
        step();
        iss_valid = 0;
        #2;
        chk("t5_busy7",  64'(busy_vec),  64'h80);
        step();
        exu_valid = 1; exu_rd = 5'd9; exu_data = 32'h99;
        step();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 5'd9;
        #2;
        chk("t5_iss9",   64'(iss_ready), 64'd1);
        chk("t5_waddr9", 64'(rf_waddr),  64'd9);
        step();
        iss_valid = 0;
        #2;
        chk("t5_setwin", 64'(busy_vec),  64'h280);
        chk("t5_msetwin",64'(m_busy),    64'h280);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();

`ifdef RF_WB_RR_EN
        // Both held valid: grants alternate starting with EXU
        exu_valid = 1; exu_rd = 5'd10; exu_data = 32'hA0;
        lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("t4_exu", 64'(exu_ready), 64'((k % 2) == 0));
            chk("t4_lsu", 64'(lsu_ready), 64'((k % 2) == 1));
            step();
        end
        exu_valid = 0; lsu_valid = 0;
`else
        // Conflict under fixed priority: LSU first, EXU next cycle
        exu_valid = 1; exu_rd = 5'd3; exu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h44;
        #2;
        chk("t3_lsu", 64'(lsu_ready), 64'd1);
        chk("t3_exu", 64'(exu_ready), 64'd0);
        step();
        lsu_valid = 0;
        #2;
        chk("t3_exu2",  64'(exu_ready), 64'd1);
        chk("t3_wen4",  64'(rf_wen),    64'd1);
        chk("t3_addr4", 64'(rf_waddr),  64'd4);
        chk("t3_data4", 64'(rf_wdata),  64'h44);
        step();
        exu_valid = 0;
        #2;
        chk("t3_wen3",  64'(rf_wen),    64'd1);
        chk("t3_addr3", 64'(rf_waddr),  64'd3);
        chk("t3_data3", 64'(rf_wdata),  64'h33);
        step();
`endif

        // Writeback and issue to x0
        iss_valid = 1; iss_rd = 5'd2;
        step();
        iss_valid = 0;
        exu_valid = 1; exu_rd = 5'd0; exu_data = 32'hFFFF_FFFF;
        #2;
        chk("t6_rdy",   64'(exu_ready), 64'd1);
        chk("t6_busy",  64'(busy_vec),  64'h4);
        step();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 5'd0;
        #2;
        chk("t6_wen",   64'(rf_wen),    64'd0);
        chk("t6_iss0",  64'(iss_ready), 64'd1);
        step();
        iss_valid = 0;
        #2;
        chk("t6_busy2", 64'(busy_vec),  64'h4);
        step();

        // Randomized traffic; requesters hold rd/data until accepted
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 199) != 0);
            if (!exu_valid || m_acc_exu) begin
                exu_valid = ($urandom_range(0, 99) < 55);
                exu_rd    = pick_rd();
                exu_data  = $urandom;
            end
            if (!lsu_valid || m_acc_lsu) begin
                lsu_valid = ($urandom_range(0, 99) < 45);
                lsu_rd    = pick_rd();
                lsu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 99) < 40);
            iss_rd    = pick_rd();
            rs1       = pick_rd();
            rs2       = pick_rd();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
